// File: rtl/mlsu_ld_txn_gen_if.sv
// Bundle for mlsu_ld_txn_gen: matrix-load request, AXI AR channel and the
// per-beat txn_ctrl word for the sequential load unit.
// The master modport is the generator's view; slave is the environment's.
interface mlsu_ld_txn_gen_if #(
  parameter int unsigned AxiDataWidth = 128,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned LenWidth     = 32
);
  localparam int unsigned BusNSize = $clog2(AxiDataWidth / 4);

  // request front end
  logic                    req_valid_i;
  logic                    req_ready_o;
  logic [AxiAddrWidth-1:0] req_addr_i;
  logic [LenWidth-1:0]     req_nbytes_i;

  // AXI AR channel
  logic                    ar_valid_o;
  logic                    ar_ready_i;
  logic [AxiAddrWidth-1:0] ar_addr_o;
  logic [7:0]              ar_len_o;
  logic [2:0]              ar_size_o;
  logic [1:0]              ar_burst_o;

  // per-beat transaction control
  logic                    txn_valid_o;
  logic                    txn_ready_i;
  logic [AxiAddrWidth-1:0] txn_addr_o;
  logic                    txn_is_head_o;
  logic                    txn_is_final_o;
  logic [7:0]              txn_rmn_beat_o;
  logic [BusNSize:0]       txn_lbn_o;

  modport master (
    input  req_valid_i, req_addr_i, req_nbytes_i, ar_ready_i, txn_ready_i,
    output req_ready_o, ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o,
           txn_valid_o, txn_addr_o, txn_is_head_o, txn_is_final_o,
           txn_rmn_beat_o, txn_lbn_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_nbytes_i, ar_ready_i, txn_ready_i,
    input  req_ready_o, ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o,
           txn_valid_o, txn_addr_o, txn_is_head_o, txn_is_final_o,
           txn_rmn_beat_o, txn_lbn_o
  );
endinterface

// File: rtl/mlsu_ld_txn_gen.sv
// Matrix sequential-load transaction generator. Splits one contiguous byte
// request into 4 KiB-safe AXI INCR read bursts and, through a small burst
// descriptor FIFO, emits one txn_ctrl word per R beat in order.
module mlsu_ld_txn_gen #(
  parameter int unsigned AxiDataWidth = 128,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned LenWidth     = 32,
  parameter int unsigned MaxBurstLen  = 16,
  parameter int unsigned DescDepth    = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  mlsu_ld_txn_gen_if.master bus
);
  localparam int unsigned BusBytes   = AxiDataWidth / 8;
  localparam int unsigned BusNibbles = AxiDataWidth / 4;
  localparam int unsigned BusNSize   = $clog2(BusNibbles);
  localparam int unsigned SizeW      = $clog2(BusBytes);
  localparam int unsigned EoW        = SizeW + 1;
  localparam int unsigned RmnW       = LenWidth + 1;
  localparam int unsigned PageBeats  = 4096 / BusBytes;
  localparam int unsigned PtrW       = (DescDepth > 1) ? $clog2(DescDepth) : 1;
  localparam int unsigned CntW       = $clog2(DescDepth + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_e;

  function automatic logic [RmnW-1:0] min_u(input logic [RmnW-1:0] a,
                                            input logic [RmnW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(DescDepth - 1)) begin
      return {PtrW{1'b0}};
    end else begin
      return p + PtrW'(1);
    end
  endfunction

  // issue-side state
  state_e                  state_q, state_d;
  logic [AxiAddrWidth-1:0] cur_addr_q, cur_addr_d;
  logic [AxiAddrWidth-1:0] start_addr_q, start_addr_d;
  logic [RmnW-1:0]         rmn_total_q, rmn_total_d;
  logic [EoW-1:0]          end_off_q, end_off_d;
  logic                    head_pend_q, head_pend_d;

  // burst descriptor FIFO
  logic [AxiAddrWidth-1:0] desc_addr_q  [DescDepth];
  logic [7:0]              desc_len_q   [DescDepth];
  logic                    desc_head_q  [DescDepth];
  logic                    desc_final_q [DescDepth];
  logic [EoW-1:0]          desc_eoff_q  [DescDepth];
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]         cnt_q;
  logic [7:0]              bc_q;

  // combinational helpers
  logic [RmnW-1:0]  page_beats_s, nb_s, span_s;
  logic [SizeW-1:0] last_low_s;
  logic             desc_full_s, desc_empty_s;
  logic             req_hs_s, ar_valid_s, push_s, final_s;
  logic             beat_s, pop_s;
  logic [7:0]       rmn_beat_s;

  // Burst sizing: never beyond MaxBurstLen, the request, or the 4 KiB page.
  always_comb begin
    page_beats_s = RmnW'(PageBeats) - RmnW'(cur_addr_q[11:SizeW]);
    nb_s         = min_u(min_u(RmnW'(MaxBurstLen), rmn_total_q), page_beats_s);
    final_s      = (nb_s == rmn_total_q);
    desc_full_s  = (cnt_q == CntW'(DescDepth));
    desc_empty_s = (cnt_q == {CntW{1'b0}});
    req_hs_s     = (state_q == IDLE) && bus.req_valid_i;
    ar_valid_s   = (state_q == SPLIT) && !desc_full_s;
    push_s       = ar_valid_s && bus.ar_ready_i;
    rmn_beat_s   = desc_len_q[rd_ptr_q] - bc_q;
    beat_s       = !desc_empty_s && bus.txn_ready_i;
    pop_s        = beat_s && (rmn_beat_s == 8'd0);
    // beat count covering the start offset inside the first bus word
    span_s       = RmnW'(bus.req_addr_i[SizeW-1:0]) + RmnW'(bus.req_nbytes_i)
                 + RmnW'(BusBytes - 1);
    last_low_s   = bus.req_addr_i[SizeW-1:0] + bus.req_nbytes_i[SizeW-1:0]
                 - SizeW'(1);
  end

  // Issue FSM next state: latch a request, then walk it burst by burst.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    start_addr_d = start_addr_q;
    rmn_total_d  = rmn_total_q;
    end_off_d    = end_off_q;
    head_pend_d  = head_pend_q;
    case (state_q)
      IDLE: begin
        if (req_hs_s) begin
          cur_addr_d   = {bus.req_addr_i[AxiAddrWidth-1:SizeW], {SizeW{1'b0}}};
          start_addr_d = bus.req_addr_i;
          rmn_total_d  = span_s >> SizeW;
          end_off_d    = {1'b0, last_low_s} + EoW'(1);
          head_pend_d  = 1'b1;
          state_d      = SPLIT;
        end else begin
          state_d      = IDLE;
        end
      end
      SPLIT: begin
        if (push_s) begin
          cur_addr_d  = cur_addr_q + (AxiAddrWidth'(nb_s) << SizeW);
          rmn_total_d = rmn_total_q - nb_s;
          head_pend_d = 1'b0;
          state_d     = final_s ? IDLE : SPLIT;
        end else begin
          state_d     = SPLIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Issue FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cur_addr_q   <= {AxiAddrWidth{1'b0}};
      start_addr_q <= {AxiAddrWidth{1'b0}};
      rmn_total_q  <= {RmnW{1'b0}};
      end_off_q    <= {EoW{1'b0}};
      head_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      start_addr_q <= start_addr_d;
      rmn_total_q  <= rmn_total_d;
      end_off_q    <= end_off_d;
      head_pend_q  <= head_pend_d;
    end
  end

  // Descriptor FIFO: push on AR handshake, pop when a burst's last beat is taken.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DescDepth); i++) begin
        desc_addr_q[i]  <= {AxiAddrWidth{1'b0}};
        desc_len_q[i]   <= 8'd0;
        desc_head_q[i]  <= 1'b0;
        desc_final_q[i] <= 1'b0;
        desc_eoff_q[i]  <= {EoW{1'b0}};
      end
      wr_ptr_q <= {PtrW{1'b0}};
      rd_ptr_q <= {PtrW{1'b0}};
      cnt_q    <= {CntW{1'b0}};
    end else begin
      if (push_s) begin
        // the head burst keeps the unaligned start so the consumer sees the offset
        desc_addr_q[wr_ptr_q]  <= head_pend_q ? start_addr_q : cur_addr_q;
        desc_len_q[wr_ptr_q]   <= nb_s[7:0] - 8'd1;
        desc_head_q[wr_ptr_q]  <= head_pend_q;
        desc_final_q[wr_ptr_q] <= final_s;
        desc_eoff_q[wr_ptr_q]  <= end_off_q;
        wr_ptr_q               <= ptr_inc(wr_ptr_q);
      end
      if (pop_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Beat counter within the head descriptor's burst.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bc_q <= 8'd0;
    end else if (beat_s) begin
      bc_q <= (rmn_beat_s == 8'd0) ? 8'd0 : bc_q + 8'd1;
    end else begin
      bc_q <= bc_q;
    end
  end

  assign bus.req_ready_o    = (state_q == IDLE);
  assign bus.ar_valid_o     = ar_valid_s;
  assign bus.ar_addr_o      = cur_addr_q;
  assign bus.ar_len_o       = nb_s[7:0] - 8'd1;
  assign bus.ar_size_o      = 3'(SizeW);
  assign bus.ar_burst_o     = 2'b01;
  assign bus.txn_valid_o    = !desc_empty_s;
  assign bus.txn_addr_o     = desc_addr_q[rd_ptr_q] << 1;
  assign bus.txn_is_head_o  = desc_head_q[rd_ptr_q] && (bc_q == 8'd0);
  assign bus.txn_is_final_o = desc_final_q[rd_ptr_q];
  assign bus.txn_rmn_beat_o = rmn_beat_s;
  assign bus.txn_lbn_o      = (desc_final_q[rd_ptr_q] && (rmn_beat_s == 8'd0))
                            ? {desc_eoff_q[rd_ptr_q], 1'b0}
                            : (BusNSize + 1)'(BusNibbles);

  // Request legality and descriptor FIFO integrity.
  a_nbytes_nz: assert property (@(posedge clk_i) disable iff (!rst_ni)
    req_hs_s |-> (bus.req_nbytes_i != {LenWidth{1'b0}}));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push_s |-> !desc_full_s);
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    beat_s |-> !desc_empty_s);
  a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= CntW'(DescDepth));
endmodule

// File: tb/tb_mlsu_ld_txn_gen.sv
// Self-checking bench for mlsu_ld_txn_gen: expected AR bursts and txn beats
// are queued when a request is driven and compared as the DUT hands them out.
module tb_mlsu_ld_txn_gen;
  localparam int unsigned DW = 128, AW = 64, LW = 32, MBL = 16, DD = 2;

  logic clk;
  logic rst_n;

  mlsu_ld_txn_gen_if #(.AxiDataWidth(DW), .AxiAddrWidth(AW), .LenWidth(LW)) bus ();

  mlsu_ld_txn_gen #(
    .AxiDataWidth(DW), .AxiAddrWidth(AW), .LenWidth(LW),
    .MaxBurstLen(MBL), .DescDepth(DD)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
  } ar_t;

  typedef struct packed {
    logic [63:0] addr;
    logic        head;
    logic        fin;
    logic [7:0]  rmn;
    logic [5:0]  lbn;
  } txn_t;

  ar_t  ar_q[$];
  txn_t txn_q[$];
  ar_t  mon_ar_got, mon_ar_exp;
  txn_t mon_tx_got, mon_tx_exp;
  int   checks   = 0;
  int   failures = 0;
  int   ar_seen  = 0;
  bit   mon_en   = 1'b0;

  // Scoreboard monitor: sample half a cycle before the edge that completes a handshake.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (bus.ar_valid_o && bus.ar_ready_i) begin
        mon_ar_got.addr = bus.ar_addr_o;
        mon_ar_got.len  = bus.ar_len_o;
        ar_seen++;
        checks++;
        if (ar_q.size() == 0) begin
          failures++;
          $display("FAIL ar_extra got addr=%h len=%0d, required no AR", mon_ar_got.addr, mon_ar_got.len);
        end else begin
          mon_ar_exp = ar_q.pop_front();
          if (mon_ar_got !== mon_ar_exp || bus.ar_size_o !== 3'd4 || bus.ar_burst_o !== 2'b01) begin
            failures++;
            $display("FAIL ar_cmp got addr=%h len=%0d size=%0d burst=%0d, required addr=%h len=%0d size=4 burst=1",
                     mon_ar_got.addr, mon_ar_got.len, bus.ar_size_o, bus.ar_burst_o,
                     mon_ar_exp.addr, mon_ar_exp.len);
          end
        end
      end
      if (bus.txn_valid_o && bus.txn_ready_i) begin
        mon_tx_got.addr = bus.txn_addr_o;
        mon_tx_got.head = bus.txn_is_head_o;
        mon_tx_got.fin  = bus.txn_is_final_o;
        mon_tx_got.rmn  = bus.txn_rmn_beat_o;
        mon_tx_got.lbn  = bus.txn_lbn_o;
        checks++;
        if (txn_q.size() == 0) begin
          failures++;
          $display("FAIL txn_extra got addr=%h rmn=%0d, required no beat", mon_tx_got.addr, mon_tx_got.rmn);
        end else begin
          mon_tx_exp = txn_q.pop_front();
          if (mon_tx_got !== mon_tx_exp) begin
            failures++;
            $display("FAIL txn_cmp got addr=%h head=%0d final=%0d rmn=%0d lbn=%0d, required addr=%h head=%0d final=%0d rmn=%0d lbn=%0d",
                     mon_tx_got.addr, mon_tx_got.head, mon_tx_got.fin, mon_tx_got.rmn, mon_tx_got.lbn,
                     mon_tx_exp.addr, mon_tx_exp.head, mon_tx_exp.fin, mon_tx_exp.rmn, mon_tx_exp.lbn);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic exp_ar(input logic [63:0] a, input logic [7:0] len);
    ar_t e;
    e.addr = a;
    e.len  = len;
    ar_q.push_back(e);
  endtask

  task automatic exp_txn(input logic [63:0] a, input logic h, input logic f,
                         input logic [7:0] rmn, input logic [5:0] lbn);
    txn_t e;
    e.addr = a;
    e.head = h;
    e.fin  = f;
    e.rmn  = rmn;
    e.lbn  = lbn;
    txn_q.push_back(e);
  endtask

  // Reference model in byte terms: walk aligned bursts up to the rounded-up end.
  task automatic model_req(input logic [63:0] addr, input logic [31:0] nbytes);
    logic [63:0] e, end_al, a, be, page_end;
    int          beats;
    bit          first, fin;
    e      = addr + 64'(nbytes);
    end_al = (e + 64'd15) & ~64'hF;
    a      = addr & ~64'hF;
    first  = 1'b1;
    while (a < end_al) begin
      page_end = (a | 64'hFFF) + 64'd1;
      be = a + 64'd256;
      if (be > page_end) be = page_end;
      if (be > end_al)   be = end_al;
      beats = int'((be - a) >> 4);
      fin   = (be == end_al);
      exp_ar(a, 8'(beats - 1));
      for (int j = 0; j < beats; j++) begin
        exp_txn((first ? addr : a) << 1, first && (j == 0), fin, 8'(beats - 1 - j),
                (fin && j == beats - 1) ? 6'(64'd2 * (e - (be - 64'd16))) : 6'd32);
      end
      first = 1'b0;
      a = be;
    end
  endtask

  task automatic send_req(input logic [63:0] a, input logic [31:0] n);
    int t = 0;
    while (bus.req_ready_o !== 1'b1 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (bus.req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL req_ready_timeout got %b, required 1", bus.req_ready_o);
    end
    bus.req_valid_i  = 1'b1;
    bus.req_addr_i   = a;
    bus.req_nbytes_i = n;
    @(posedge clk); #1;
    bus.req_valid_i  = 1'b0;
  endtask

  task automatic send_modeled(input logic [63:0] a, input logic [31:0] n);
    model_req(a, n);
    send_req(a, n);
  endtask

  task automatic wait_drain(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (ar_q.size() == 0 && txn_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bit ok;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.req_ready_o, bus.ar_valid_o, bus.txn_valid_o} !== 3'b100) begin
      failures++;
      $display("FAIL reset_state got req_ready=%b ar_valid=%b txn_valid=%b, required 1 0 0",
               bus.req_ready_o, bus.ar_valid_o, bus.txn_valid_o);
    end
    mon_en = 1'b1;
    ok = 1'b1;
  endtask

  task automatic test_single_beat();
    bit ok;
    bus.ar_ready_i  = 1'b1;
    bus.txn_ready_i = 1'b1;
    exp_ar(64'h1000, 8'd0);
    exp_txn(64'h2008, 1'b1, 1'b1, 8'd0, 6'd24);
    send_req(64'h1004, 32'd8);
    checks++;
    if (bus.ar_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL ar_valid_latency got %b, required 1", bus.ar_valid_o);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.txn_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL txn_valid_latency got %b, required 1", bus.txn_valid_o);
    end
    wait_drain(100, ok);
    checks++;
    if (!ok || bus.ar_valid_o !== 1'b0 || bus.txn_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL single_drain got pending ar=%0d txn=%0d ar_valid=%b txn_valid=%b, required 0 0 0 0",
               ar_q.size(), txn_q.size(), bus.ar_valid_o, bus.txn_valid_o);
    end
  endtask

  task automatic test_multi_burst();
    bit ok;
    exp_ar(64'h000, 8'd15);
    exp_ar(64'h100, 8'd15);
    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j < 16; j++) begin
        exp_txn(b == 0 ? 64'h0 : 64'h200, (b == 0) && (j == 0), b == 1, 8'(15 - j), 6'd32);
      end
    end
    send_req(64'h0, 32'd512);
    checks++;
    if (bus.req_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL req_ready_busy got %b, required 0", bus.req_ready_o);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL req_ready_return got %b, required 1", bus.req_ready_o);
    end
    wait_drain(200, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL multi_drain got pending ar=%0d txn=%0d, required 0 0", ar_q.size(), txn_q.size());
    end
  endtask

  task automatic test_page_cross();
    bit ok;
    exp_ar(64'hFF0, 8'd0);
    exp_ar(64'h1000, 8'd1);
    exp_txn(64'h1FE0, 1'b1, 1'b0, 8'd0, 6'd32);
    exp_txn(64'h2000, 1'b0, 1'b1, 8'd1, 6'd32);
    exp_txn(64'h2000, 1'b0, 1'b1, 8'd0, 6'd32);
    send_req(64'hFF0, 32'd48);
    wait_drain(100, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL page_drain got pending ar=%0d txn=%0d, required 0 0", ar_q.size(), txn_q.size());
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [63:0] sa, ta;
    logic [7:0]  sl, tr;
    logic        th, tf;
    logic [5:0]  tl;
    int          t;
    bus.ar_ready_i  = 1'b0;
    bus.txn_ready_i = 1'b0;
    send_modeled(64'h40, 32'd512);
    @(negedge clk);
    sa = bus.ar_addr_o;
    sl = bus.ar_len_o;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.ar_valid_o !== 1'b1 || bus.ar_addr_o !== sa || bus.ar_len_o !== sl || bus.txn_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL ar_stall_hold got valid=%b addr=%h len=%0d txn_valid=%b, required 1 %h %0d 0",
                 bus.ar_valid_o, bus.ar_addr_o, bus.ar_len_o, bus.txn_valid_o, sa, sl);
      end
    end
    bus.ar_ready_i = 1'b1;
    t = 0;
    while (bus.txn_valid_o !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    ta = bus.txn_addr_o; th = bus.txn_is_head_o; tf = bus.txn_is_final_o;
    tr = bus.txn_rmn_beat_o; tl = bus.txn_lbn_o;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.txn_valid_o !== 1'b1 || bus.txn_addr_o !== ta || bus.txn_is_head_o !== th ||
          bus.txn_is_final_o !== tf || bus.txn_rmn_beat_o !== tr || bus.txn_lbn_o !== tl ||
          tr !== 8'd15) begin
        failures++;
        $display("FAIL txn_stall_hold got valid=%b addr=%h rmn=%0d, required 1 %h 15",
                 bus.txn_valid_o, bus.txn_addr_o, bus.txn_rmn_beat_o, ta);
      end
    end
    bus.txn_ready_i = 1'b1;
    wait_drain(300, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stall_drain got pending ar=%0d txn=%0d, required 0 0", ar_q.size(), txn_q.size());
    end
  endtask

  task automatic test_fifo_full();
    bit ok, early, seen;
    int ar0;
    bus.ar_ready_i  = 1'b1;
    bus.txn_ready_i = 1'b0;
    ar0 = ar_seen;
    send_modeled(64'h0, 32'd1024);
    repeat (6) @(negedge clk);
    checks++;
    if (ar_seen - ar0 !== 2 || bus.ar_valid_o !== 1'b0 || bus.txn_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL fifo_full got ars=%0d ar_valid=%b txn_valid=%b, required 2 0 1",
               ar_seen - ar0, bus.ar_valid_o, bus.txn_valid_o);
    end
    bus.txn_ready_i = 1'b1;
    early = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ar_valid_o !== 1'b0) early = 1'b1;
      if (bus.txn_valid_o === 1'b1 && bus.txn_rmn_beat_o === 8'd0) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (early || !seen) begin
      failures++;
      $display("FAIL fifo_hold got early_ar_valid=%b last_beat_seen=%b, required 0 1", early, seen);
    end
    @(negedge clk);
    checks++;
    if (bus.ar_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL fifo_release got ar_valid=%b, required 1", bus.ar_valid_o);
    end
    wait_drain(300, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL fifo_drain got pending ar=%0d txn=%0d, required 0 0", ar_q.size(), txn_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    mon_en = 1'b0;
    bus.ar_ready_i  = 1'b1;
    bus.txn_ready_i = 1'b0;
    send_req(64'h0, 32'd1024);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({bus.req_ready_o, bus.ar_valid_o, bus.txn_valid_o} !== 3'b001) begin
      failures++;
      $display("FAIL mid_precond got req_ready=%b ar_valid=%b txn_valid=%b, required 0 0 1",
               bus.req_ready_o, bus.ar_valid_o, bus.txn_valid_o);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if ({bus.req_ready_o, bus.ar_valid_o, bus.txn_valid_o} !== 3'b100) begin
      failures++;
      $display("FAIL mid_reset got req_ready=%b ar_valid=%b txn_valid=%b, required 1 0 0",
               bus.req_ready_o, bus.ar_valid_o, bus.txn_valid_o);
    end
    ar_q.delete();
    txn_q.delete();
    mon_en = 1'b1;
    bus.txn_ready_i = 1'b1;
    send_modeled(64'h1004, 32'd8);
    send_modeled(64'h2F8, 32'd40);
    wait_drain(200, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL post_reset_drain got pending ar=%0d txn=%0d, required 0 0", ar_q.size(), txn_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok, done;
    done = 1'b0;
    fork
      begin
        for (int r = 0; r < 8; r++) begin
          send_modeled(64'($urandom_range(0, 32'h3FFF)), 32'($urandom_range(1, 700)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.ar_ready_i  = 1'($urandom_range(0, 1));
          bus.txn_ready_i = 1'($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.ar_ready_i  = 1'b1;
    bus.txn_ready_i = 1'b1;
    wait_drain(2000, ok);
    checks++;
    if (!ok || bus.ar_valid_o !== 1'b0 || bus.txn_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got pending ar=%0d txn=%0d ar_valid=%b txn_valid=%b, required 0 0 0 0",
               ar_q.size(), txn_q.size(), bus.ar_valid_o, bus.txn_valid_o);
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.req_valid_i  = 1'b0;
    bus.req_addr_i   = 64'd0;
    bus.req_nbytes_i = 32'd0;
    bus.ar_ready_i   = 1'b0;
    bus.txn_ready_i  = 1'b0;
    test_reset();
    test_single_beat();
    test_multi_burst();
    test_page_cross();
    test_stall();
    test_fifo_full();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
